// File: rtl/viterbi_pkg.sv
// Shared types and trellis helpers for the K=4, 8-state rate-1/2 Viterbi decoder.
package viterbi_pkg;
    localparam int NB_STATES = 8;
    localparam int K         = 4;
    localparam int STATE_W   = 3;
    localparam int TAIL_LEN  = 3;

    typedef logic [NB_STATES-1:0] decision_t;
    typedef logic [STATE_W-1:0]   state_t;

    typedef enum logic [1:0] {WRITE, TRACE, OUTPUT} tb_fsm_t;

    // Previous state: shift in the survivor's LSB recorded for state s.
    function automatic state_t predecessor(state_t s, decision_t d);
        return {s[1:0], d[s]};
    endfunction
endpackage

// File: rtl/survivor_mem.sv
// Per-step decision storage: synchronous write, combinational read.
module survivor_mem
    import viterbi_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  decision_t     wdata,
    input  logic [AW-1:0] raddr,
    output decision_t     rdata
);
    decision_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/viterbi_traceback.sv
// Stores one terminated frame of ACS decisions, traces it back from state 0,
// and streams the message bits out in forward order.
module viterbi_traceback
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = 64
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      enable,
    input  decision_t decision,
    output logic      busy,
    output logic      overrun,
    output logic      out_bit,
    output logic      out_valid,
    input  logic      out_ready,
    output logic      out_last
);
    localparam int PTR_W = $clog2(FRAME_LEN);
    localparam logic [PTR_W-1:0] IDX_LAST = PTR_W'(FRAME_LEN - 1);
    localparam logic [PTR_W-1:0] MSG_LAST = PTR_W'(FRAME_LEN - TAIL_LEN - 1);
    localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);

    tb_fsm_t              state_q, state_d;
    logic [PTR_W-1:0]     wr_cnt, tb_idx, rd_cnt;
    state_t               tb_state;
    logic [FRAME_LEN-1:0] bitbuf;
    decision_t            rd_word;
    logic                 wr_en, handshake;

    assign wr_en     = enable && (state_q == WRITE);
    assign busy      = (state_q != WRITE);
    assign out_valid = (state_q == OUTPUT);
    assign out_bit   = out_valid && bitbuf[rd_cnt];
    assign out_last  = out_valid && (rd_cnt == MSG_LAST);
    assign handshake = out_valid && out_ready;

    survivor_mem #(.DEPTH(FRAME_LEN), .AW(PTR_W)) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_cnt),
        .wdata (decision),
        .raddr (tb_idx),
        .rdata (rd_word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            WRITE:   if (wr_en && wr_cnt == IDX_LAST) state_d = TRACE;
            TRACE:   if (tb_idx == '0)                state_d = OUTPUT;
            OUTPUT:  if (handshake && out_last)       state_d = WRITE;
            default: state_d = WRITE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= WRITE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt   <= '0;
            tb_idx   <= '0;
            rd_cnt   <= '0;
            tb_state <= '0;
            overrun  <= 1'b0;
        end else begin
            // Words offered while busy are dropped and flagged for one cycle.
            overrun <= enable && busy;
            case (state_q)
                WRITE: if (wr_en) begin
                    if (wr_cnt == IDX_LAST) begin
                        wr_cnt   <= '0;
                        tb_idx   <= IDX_LAST;
                        tb_state <= '0;
                    end else begin
                        wr_cnt <= wr_cnt + ONE;
                    end
                end
                TRACE: begin
                    tb_state <= predecessor(tb_state, rd_word);
                    tb_idx   <= tb_idx - ONE;
                    if (tb_idx == '0) rd_cnt <= '0;
                end
                OUTPUT: if (handshake) begin
                    rd_cnt <= rd_cnt + ONE;
                    if (out_last) wr_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Bits land in reverse order during trace so reads come out forward.
    always_ff @(posedge clk) begin
        if (state_q == TRACE) bitbuf[tb_idx] <= tb_state[2];
    end
endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed checks of the traceback unit with FRAME_LEN=8.
module tb_viterbi_traceback;
    logic       clk, rst, enable, out_ready;
    logic [7:0] decision;
    logic       busy, overrun, out_bit, out_valid, out_last;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] FRAME_ZERO = 64'h0;
    localparam logic [63:0] FRAME_A    = 64'hFEFF_FFF7_FFDF_FBEF;

    viterbi_traceback #(.FRAME_LEN(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .decision  (decision),
        .busy      (busy),
        .overrun   (overrun),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [63:0] f);
        for (int t = 0; t < 8; t++) begin
            enable   = 1'b1;
            decision = f[8*t +: 8];
            tick();
        end
        enable   = 1'b0;
        decision = 8'h00;
    endtask

    // Waits for out_valid, then drains the frame; ready is dropped for
    // stall_len cycles starting at stall_from, enable pulsed at pulse_at.
    task automatic collect(input int stall_from, input int stall_len, input int pulse_at,
                           output int lat, output int nhs, output logic [7:0] bits,
                           output logic [7:0] lasts, output int ovr,
                           output bit stall_stable, output bit tmo);
        int   k;
        logic prev;
        lat = 0; nhs = 0; bits = '0; lasts = '0; ovr = 0; stall_stable = 1'b1; tmo = 1'b0;
        prev = 1'b0;
        out_ready = 1'b1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            tmo = 1'b1;
            return;
        end
        k = 0;
        while (out_valid && k < 40) begin
            out_ready = !(k >= stall_from && k < stall_from + stall_len);
            enable    = (k == pulse_at);
            decision  = 8'h00;
            if (k > stall_from && k <= stall_from + stall_len && out_bit !== prev)
                stall_stable = 1'b0;
            prev = out_bit;
            if (out_ready) begin
                if (nhs < 8) begin
                    bits[nhs]  = out_bit;
                    lasts[nhs] = out_last;
                end
                nhs++;
            end
            if (overrun) ovr++;
            tick();
            k++;
        end
        if (overrun) ovr++;
        enable    = 1'b0;
        out_ready = 1'b1;
        if (out_valid) tmo = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; decision = 8'h00; out_ready = 1'b1;
        #3;
        checks++;
        if ({busy, overrun, out_valid, out_bit, out_last} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {busy, overrun, out_valid, out_bit, out_last});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_all_zero();
        int lat, nhs, ovr; logic [7:0] bits, lasts; bit st, tmo;
        send_frame(FRAME_ZERO);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL zero_busy_after_last: got %b want 1", busy);
        end
        collect(99, 0, -1, lat, nhs, bits, lasts, ovr, st, tmo);
        checks++;
        if (tmo || nhs != 5) begin
            failures++; $display("FAIL zero_count: got %0d tmo=%0b want 5", nhs, tmo);
        end
        checks++;
        if (bits !== 8'h00 || lasts !== 8'h10) begin
            failures++; $display("FAIL zero_bits: got bits=%h last=%h want 00/10", bits, lasts);
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL zero_idle_after: got busy=%b valid=%b want 0/0", busy, out_valid);
        end
    endtask

    task automatic test_decode();
        int lat, nhs, ovr; logic [7:0] bits, lasts; bit st, tmo;
        send_frame(FRAME_A);
        collect(99, 0, -1, lat, nhs, bits, lasts, ovr, st, tmo);
        checks++;
        if (tmo || lat != 8) begin
            failures++; $display("FAIL decode_latency: got %0d tmo=%0b want 8", lat, tmo);
        end
        checks++;
        if (nhs != 5 || bits !== 8'h0D || lasts !== 8'h10) begin
            failures++; $display("FAIL decode_bits: got n=%0d bits=%h last=%h want 5/0d/10", nhs, bits, lasts);
        end
    endtask

    task automatic test_stall();
        int lat, nhs, ovr; logic [7:0] bits, lasts; bit st, tmo;
        send_frame(FRAME_A);
        collect(1, 3, -1, lat, nhs, bits, lasts, ovr, st, tmo);
        checks++;
        if (tmo || !st) begin
            failures++; $display("FAIL stall_stable: got stable=%0b tmo=%0b want 1/0", st, tmo);
        end
        checks++;
        if (nhs != 5 || bits !== 8'h0D || lasts !== 8'h10) begin
            failures++; $display("FAIL stall_bits: got n=%0d bits=%h last=%h want 5/0d/10", nhs, bits, lasts);
        end
    endtask

    task automatic test_overrun();
        int lat, nhs, ovr; logic [7:0] bits, lasts; bit st, tmo;
        send_frame(FRAME_A);
        enable = 1'b1; decision = 8'h00;
        tick();
        enable = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            failures++; $display("FAIL ovr_trace_pulse: got %b want 1", overrun);
        end
        tick();
        checks++;
        if (overrun !== 1'b0) begin
            failures++; $display("FAIL ovr_trace_clear: got %b want 0", overrun);
        end
        collect(99, 0, 1, lat, nhs, bits, lasts, ovr, st, tmo);
        checks++;
        if (tmo || ovr != 1) begin
            failures++; $display("FAIL ovr_output_pulse: got %0d cycles tmo=%0b want 1", ovr, tmo);
        end
        checks++;
        if (nhs != 5 || bits !== 8'h0D) begin
            failures++; $display("FAIL ovr_bits: got n=%0d bits=%h want 5/0d", nhs, bits);
        end
        // A clean follow-up frame only lines up if the write pointer restarted at 0.
        send_frame(FRAME_A);
        collect(99, 0, -1, lat, nhs, bits, lasts, ovr, st, tmo);
        checks++;
        if (tmo || lat != 8 || bits !== 8'h0D) begin
            failures++; $display("FAIL ovr_next_frame: got lat=%0d bits=%h tmo=%0b want 8/0d/0", lat, bits, tmo);
        end
    endtask

    task automatic test_reset_mid_trace();
        int lat, nhs, ovr; logic [7:0] bits, lasts; bit st, tmo;
        send_frame(FRAME_A);
        tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL rst_pre: got ovr=%b busy=%b want 1/1", overrun, busy);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy, overrun, out_valid} !== 3'b000) begin
            failures++; $display("FAIL rst_async: got busy/ovr/valid=%b want 000", {busy, overrun, out_valid});
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        send_frame(FRAME_ZERO);
        collect(99, 0, -1, lat, nhs, bits, lasts, ovr, st, tmo);
        checks++;
        if (tmo || lat != 8 || nhs != 5 || bits !== 8'h00) begin
            failures++; $display("FAIL rst_next_frame: got lat=%0d n=%0d bits=%h tmo=%0b want 8/5/00/0", lat, nhs, bits, tmo);
        end
    endtask

    task automatic test_back_to_back();
        int lat, nhs, ovr; logic [7:0] bits, lasts; bit st, tmo;
        send_frame(FRAME_ZERO);
        collect(99, 0, -1, lat, nhs, bits, lasts, ovr, st, tmo);
        checks++;
        if (tmo || nhs != 5 || bits !== 8'h00) begin
            failures++; $display("FAIL b2b_frame1: got n=%0d bits=%h tmo=%0b want 5/00/0", nhs, bits, tmo);
        end
        enable = 1'b1; decision = FRAME_A[7:0];
        tick();
        checks++;
        if (overrun !== 1'b0) begin
            failures++; $display("FAIL b2b_first_word_ovr: got %b want 0", overrun);
        end
        for (int t = 1; t < 8; t++) begin
            decision = FRAME_A[8*t +: 8];
            tick();
        end
        enable = 1'b0;
        collect(99, 0, -1, lat, nhs, bits, lasts, ovr, st, tmo);
        checks++;
        if (tmo || lat != 8 || nhs != 5 || bits !== 8'h0D || lasts !== 8'h10) begin
            failures++; $display("FAIL b2b_frame2: got lat=%0d n=%0d bits=%h last=%h tmo=%0b want 8/5/0d/10/0",
                                 lat, nhs, bits, lasts, tmo);
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_decode();
        test_stall();
        test_overrun();
        test_reset_mid_trace();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
